// File: rtl/fp_norm_pkg.sv
// Shared constants and types for the fp_norm_round normalise/round pipeline.
// Round-mode selection in fp_norm_round is enabled by defining FP_ROUND_MODE_EN.
package fp_norm_pkg;

    localparam int unsigned EXP_W_DEF  = 11;
    localparam int unsigned FRAC_W_DEF = 52;
    localparam int unsigned EXP_MAX    = (1 << EXP_W_DEF) - 1;

    localparam int unsigned FLAG_OVF  = 0;
    localparam int unsigned FLAG_UNF  = 1;
    localparam int unsigned FLAG_INX  = 2;
    localparam int unsigned FLAG_ZERO = 3;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rm_t;

    // Per-beat control that travels alongside the mantissa/exponent payload.
    typedef struct packed {
        logic sign;
        logic zero;
        rm_t  rm;
    } ctl_t;

endpackage

// File: rtl/fp_norm_round_lzc53.sv
// Combinational leading-zero counter; count equals W when the input is all zero.
module lzc53 #(
    parameter int unsigned W  = 53,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  val,
    output logic [CW-1:0] cnt,
    output logic          all_zero
);

    // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
    always_comb begin
        cnt = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (val[i]) cnt = CW'(W - 1 - i);
        end
    end

    assign all_zero = (val == '0);

endmodule

// File: rtl/fp_norm_round.sv
// Three-stage FP normaliser/rounder (detect, shift, round) with valid/ready flow.
// Define FP_ROUND_MODE_EN to add the in_rm port and RTZ/RUP/RDN rounding.
module fp_norm_round
    import fp_norm_pkg::*;
#(
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W+1:0] in_mant,
    input  logic [2:0]        in_grs,
`ifdef FP_ROUND_MODE_EN
    input  logic [1:0]        in_rm,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic [3:0]        out_flags
);

    localparam int unsigned MW = FRAC_W + 1;
    localparam int unsigned CW = $clog2(MW + 1);
    localparam int unsigned XW = EXP_W + 1;
    localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

    logic v1, v2, v3;
    logic rdy1, rdy2, rdy3;

    assign rdy3      = !v3 || out_ready;
    assign rdy2      = !v2 || rdy3;
    assign rdy1      = !v1 || rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v3;

    // ---------------- S1: detect ----------------
    logic [CW-1:0] lz;
    logic          lz_zero;

    lzc53 #(.W(MW), .CW(CW)) u_lzc (
        .val      (in_mant[MW-1:0]),
        .cnt      (lz),
        .all_zero (lz_zero)
    );

    ctl_t          s1_ctl;
    logic [XW-1:0] s1_exp;
    logic [MW-1:0] s1_mant;
    logic [2:0]    s1_grs;
    logic [CW-1:0] s1_lz;

    always_comb begin
        s1_ctl.sign = in_sign;
        s1_ctl.zero = lz_zero && !in_mant[MW] && (in_grs == '0);
`ifdef FP_ROUND_MODE_EN
        s1_ctl.rm   = rm_t'(in_rm);
`else
        s1_ctl.rm   = RM_RNE;
`endif
        s1_exp = (in_exp == '0) ? XW'(1) : {1'b0, in_exp};
        if (in_mant[MW]) begin
            // Carry-out: one-bit right shift folds the old G/R/S down a place.
            s1_mant = in_mant[MW:1];
            s1_grs  = {in_mant[0], in_grs[2], in_grs[1] | in_grs[0]};
            s1_exp  = s1_exp + XW'(1);
            s1_lz   = '0;
        end else begin
            s1_mant = in_mant[MW-1:0];
            s1_grs  = in_grs;
            s1_lz   = lz;
        end
    end

    ctl_t          r1_ctl;
    logic [XW-1:0] r1_exp;
    logic [MW-1:0] r1_mant;
    logic [2:0]    r1_grs;
    logic [CW-1:0] r1_lz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            r1_ctl  <= '0;
            r1_exp  <= '0;
            r1_mant <= '0;
            r1_grs  <= '0;
            r1_lz   <= '0;
        end else if (rdy1) begin
            v1 <= in_valid;
            if (in_valid) begin
                r1_ctl  <= s1_ctl;
                r1_exp  <= s1_exp;
                r1_mant <= s1_mant;
                r1_grs  <= s1_grs;
                r1_lz   <= s1_lz;
            end
        end
    end

    // ---------------- S2: shift ----------------
    logic [XW-1:0] s2_lim;
    logic [XW-1:0] s2_exp;
    logic          s2_sub;
    logic [CW-1:0] s2_sh;
    logic [MW+1:0] s2_vec;

    // Shift is clamped so the exponent never drops below 1; clamping means subnormal.
    always_comb begin
        s2_lim = r1_exp - XW'(1);
        s2_sub = XW'(r1_lz) > s2_lim;
        s2_sh  = s2_sub ? s2_lim[CW-1:0] : r1_lz;
        s2_vec = {r1_mant, r1_grs[2:1]} << s2_sh;
        s2_exp = r1_exp - XW'(s2_sh);
    end

    ctl_t          r2_ctl;
    logic          r2_sub;
    logic [XW-1:0] r2_exp;
    logic [MW-1:0] r2_mant;
    logic [2:0]    r2_grs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            r2_ctl  <= '0;
            r2_sub  <= 1'b0;
            r2_exp  <= '0;
            r2_mant <= '0;
            r2_grs  <= '0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                r2_ctl  <= r1_ctl;
                r2_sub  <= s2_sub;
                r2_exp  <= s2_exp;
                r2_mant <= s2_vec[MW+1:2];
                r2_grs  <= {s2_vec[1:0], r1_grs[0]};
            end
        end
    end

    // ---------------- S3: round ----------------
    logic              s3_inx;
    logic              s3_up;
    logic              s3_ovf;
    logic              s3_maxfin;
    logic [MW:0]       s3_sum;
    logic [XW-1:0]     s3_exp;
    logic [EXP_W-1:0]  s3_oexp;
    logic [FRAC_W-1:0] s3_ofrac;
    logic [3:0]        s3_flags;

    always_comb begin
        s3_inx = |r2_grs;
        case (r2_ctl.rm)
            RM_RTZ:  s3_up = 1'b0;
            RM_RUP:  s3_up = !r2_ctl.sign && s3_inx;
            RM_RDN:  s3_up = r2_ctl.sign && s3_inx;
            default: s3_up = r2_grs[2] && (r2_grs[1] || r2_grs[0] || r2_mant[0]);
        endcase
        s3_sum = {1'b0, r2_mant} + (MW + 1)'(s3_up);

        if (r2_sub)          s3_exp = s3_sum[FRAC_W] ? XW'(1) : '0;
        else if (s3_sum[MW]) s3_exp = r2_exp + XW'(1);
        else                 s3_exp = r2_exp;

        s3_ovf    = s3_exp >= EMAX;
        s3_maxfin = (r2_ctl.rm == RM_RTZ) ||
                    (r2_ctl.rm == RM_RUP && r2_ctl.sign) ||
                    (r2_ctl.rm == RM_RDN && !r2_ctl.sign);

        s3_oexp  = s3_exp[EXP_W-1:0];
        s3_ofrac = s3_sum[FRAC_W-1:0];
        s3_flags = '0;
        s3_flags[FLAG_INX] = s3_inx;
        s3_flags[FLAG_UNF] = r2_sub && s3_inx;

        if (r2_ctl.zero) begin
            s3_oexp  = '0;
            s3_ofrac = '0;
            s3_flags = '0;
            s3_flags[FLAG_ZERO] = 1'b1;
        end else if (s3_ovf) begin
            s3_flags[FLAG_OVF] = 1'b1;
            s3_flags[FLAG_INX] = 1'b1;
            if (s3_maxfin) begin
                s3_oexp  = EXP_W'(EMAX - XW'(1));
                s3_ofrac = '1;
            end else begin
                s3_oexp  = '1;
                s3_ofrac = '0;
            end
        end else begin
            s3_flags[FLAG_ZERO] = (s3_oexp == '0) && (s3_ofrac == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3        <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_frac  <= '0;
            out_flags <= '0;
        end else if (rdy3) begin
            v3 <= v2;
            if (v2) begin
                out_sign  <= r2_ctl.sign;
                out_exp   <= s3_oexp;
                out_frac  <= s3_ofrac;
                out_flags <= s3_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed self-checking bench for fp_norm_round (default RNE build).
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [10:0] in_exp = '0;
    logic [53:0] in_mant = '0;
    logic [2:0]  in_grs = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [10:0] out_exp;
    logic [51:0] out_frac;
    logic [3:0]  out_flags;
`ifdef FP_ROUND_MODE_EN
    logic [1:0]  in_rm = 2'd0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_norm_round #(.EXP_W(11), .FRAC_W(52)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_grs    (in_grs),
`ifdef FP_ROUND_MODE_EN
        .in_rm     (in_rm),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_flags (out_flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic send(input string tag, input logic s, input logic [10:0] e,
                        input logic [53:0] m, input logic [2:0] g);
        int unsigned n;
        logic acc;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_grs   = g;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = in_ready;
        if (acc) @(posedge clk);
        #1 in_valid = 1'b0;
        check({tag, "/accept"}, 64'(acc), 64'd1);
    endtask

    task automatic expect_out(input string tag, input logic s, input logic [10:0] e,
                              input logic [51:0] f, input logic [3:0] fl,
                              output int unsigned lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/valid"}, 64'(out_valid), 64'd1);
        check({tag, "/sign"},  64'(out_sign),  64'(s));
        check({tag, "/exp"},   64'(out_exp),   64'(e));
        check({tag, "/frac"},  64'(out_frac),  64'(f));
        check({tag, "/flags"}, 64'(out_flags), 64'(fl));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        int unsigned idx;
        int unsigned stale;
        logic acc;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/valid", 64'(out_valid), 64'd0);
        check("rst/ready", 64'(in_ready),  64'd1);
        check("rst/exp",   64'(out_exp),   64'd0);
        check("rst/frac",  64'(out_frac),  64'd0);
        check("rst/flags", 64'(out_flags), 64'd0);
        rst_n = 1'b1;

        // Reset mid-flight with three beats in the pipe
        send("mf0", 1'b0, 11'd300, 54'd1 << 52, 3'b000);
        send("mf1", 1'b0, 11'd301, 54'd1 << 52, 3'b000);
        send("mf2", 1'b0, 11'd302, 54'd1 << 52, 3'b000);
        check("mf/full", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mf/valid", 64'(out_valid), 64'd0);
        check("mf/ready", 64'(in_ready),  64'd1);
        check("mf/exp",   64'(out_exp),   64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("mf/stale", 64'(stale), 64'd0);
        check("mf/ready2", 64'(in_ready), 64'd1);

        // Carry normalise, with latency check
        send("carry", 1'b0, 11'd1023, 54'd1 << 53, 3'b000);
        expect_out("carry", 1'b0, 11'd1024, 52'd0, 4'b0000, lat);
        check("carry/latency", 64'(lat), 64'd3);

        // Left normalise, normal and subnormal
        send("left", 1'b0, 11'd1023, 54'd1 << 40, 3'b000);
        expect_out("left", 1'b0, 11'd1011, 52'd0, 4'b0000, lat);
        send("leftsub", 1'b0, 11'd5, 54'd1 << 40, 3'b000);
        expect_out("leftsub", 1'b0, 11'd0, 52'd1 << 44, 4'b0000, lat);

        // RNE ties
        send("tieodd", 1'b0, 11'd1023, (54'd1 << 52) | 54'd1, 3'b100);
        expect_out("tieodd", 1'b0, 11'd1023, 52'd2, 4'b0100, lat);
        send("tieeven", 1'b1, 11'd1023, 54'd1 << 52, 3'b100);
        expect_out("tieeven", 1'b1, 11'd1023, 52'd0, 4'b0100, lat);

        // Rounding carry-out of the mantissa
        send("rndcarry", 1'b0, 11'd1023, {2'b01, {52{1'b1}}}, 3'b110);
        expect_out("rndcarry", 1'b0, 11'd1024, 52'd0, 4'b0100, lat);

        // Subnormal rounding up into the hidden bit
        send("subrnd", 1'b0, 11'd0, {2'b00, {52{1'b1}}}, 3'b110);
        expect_out("subrnd", 1'b0, 11'd1, 52'd0, 4'b0110, lat);

        // Overflow to infinity
        send("ovf", 1'b0, 11'd2046, 54'd1 << 53, 3'b000);
        expect_out("ovf", 1'b0, 11'd2047, 52'd0, 4'b0101, lat);

        // Exact zero keeps its sign
        send("zero", 1'b1, 11'd77, 54'd0, 3'b000);
        expect_out("zero", 1'b1, 11'd0, 52'd0, 4'b1000, lat);

        // Backpressure: five beats, sink stalled for six cycles
        @(negedge clk);
        out_ready = 1'b0;
        idx = 0;
        repeat (6) begin
            @(negedge clk);
            acc = 1'b0;
            if (idx < 5) begin
                in_valid = 1'b1;
                in_sign  = 1'b0;
                in_exp   = 11'(200 + idx);
                in_mant  = (54'd1 << 52) | 54'(idx + 1);
                in_grs   = 3'b000;
                acc      = in_ready;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            if (acc) idx++;
        end
        check("bp/accepted", 64'(idx), 64'd3);
        check("bp/ready",    64'(in_ready),  64'd0);
        check("bp/valid",    64'(out_valid), 64'd1);
        check("bp/held",     64'(out_frac),  64'd1);
        out_ready = 1'b1;
        fork
            begin
                send("bp3", 1'b0, 11'd203, (54'd1 << 52) | 54'd4, 3'b000);
                send("bp4", 1'b0, 11'd204, (54'd1 << 52) | 54'd5, 3'b000);
            end
            begin
                for (int unsigned k = 0; k < 5; k++) begin
                    expect_out($sformatf("bp_out%0d", k), 1'b0, 11'(200 + k),
                               52'(k + 1), 4'b0000, lat);
                end
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Pipelined post-arithmetic normaliser and rounder for the double-precision FP datapath.
- Accepts a raw 54-bit mantissa with guard/round/sticky bits from the add/sub/mul units.
- Computes the required shift count itself (leading-zero count, or carry detect) and applies it. It therefore produces the shift amount rather than consuming it.
- Delivers a packed, IEEE-754 round-to-nearest-even result with exception flags. Sits between the FP execute units and writeback, using a valid/ready handshake.

Parameters:
- EXP_W, 11, biased exponent width.
- FRAC_W, 52, stored fraction width. Input mantissa is FRAC_W+2 bits.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_sign  in  1  result sign
- in_exp  in  EXP_W  biased exponent; 0 treated as 1 (subnormal input)
- in_mant  in  FRAC_W+2  bit 53 = carry-out, bit 52 = hidden, 51:0 = fraction
- in_grs  in  3  guard, round, sticky
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sign  out  1  result sign
- out_exp  out  EXP_W  result biased exponent
- out_frac  out  FRAC_W  result fraction
- out_flags  out  4  {zero, inexact, underflow, overflow}, overflow = bit 0

Behaviour:
- Reset: all stage valids cleared. out_valid=0, all data outputs and out_flags 0, in_ready=1. Reset asserted mid-operation discards in-flight beats immediately (asynchronous).
- Pipeline: 3 stages, S1 detect, S2 shift, S3 round. Latency is exactly 3 cycles from accepted beat to out_valid with no backpressure.
- Accept: a beat is accepted when in_valid && in_ready.
- Stall logic: per-stage ready_k = !v_k || ready_{k+1}; ready_4 = out_ready; in_ready = ready_1. Bubbles collapse.
- Ordering: results emerge in order. No beat is lost or duplicated.
- out_* held stable while out_valid && !out_ready.
- S1, carry case: in_mant[53]=1 → right shift 1, exp+1. Shifted-out bit becomes G, old G becomes R, sticky = R|S.
- S1, normal case: else lzc = leading zeros of in_mant[52:0], range 0..53.
- S1, zero case: in_mant==0 and in_grs==0 → zero result: exp 0, frac 0, flags zero only. Sign preserved.
- S2, left shift: shift {mant[52:0],G,R} left by sh, zero fill; S unchanged. sh = min(lzc, exp_eff-1); exp = exp_eff-sh.
- S2, subnormal: if lzc > exp_eff-1, result is subnormal and out_exp=0.
- S3, round (RNE): up = G & (R|S|lsb). Mantissa increment carry-out → frac 0, exp+1. Subnormal rounding into bit 52 → exp 1.
- inexact = G|R|S before rounding.
- underflow = subnormal && inexact.
- Overflow: final exp ≥ 2^EXP_W−1 → out_exp all ones, frac 0 (infinity), flags overflow|inexact.

Optional Feature:
- Macro FP_ROUND_MODE_EN.
- Defined: adds port in_rm (in, 2), captured with the beat. Modes: 0 RNE, 1 RTZ (up=0), 2 RUP (up=!sign&(G|R|S)), 3 RDN (up=sign&(G|R|S)).
- Defined, overflow result: for RTZ, for RUP with negative sign, and for RDN with positive sign, overflow yields max finite (exp all-ones−1, frac all ones) instead of infinity.
- Undefined: no in_rm port; RNE only.

Decomposition:
- Package fp_norm_pkg: EXP_W/FRAC_W defaults, EXP_MAX constant, flag bit index constants, rounding-mode enum typedef, stage payload struct typedef.
- Sub-module lzc53: combinational leading-zero counter, 53-bit input, 6-bit count plus all-zero flag. Instantiated in S1.

Test Plan:
- Reset mid-flight: 3 beats in pipeline, rst_n low one cycle → out_valid 0 at once; after release in_ready=1 and no stale output.
- Carry normalise: in_mant=bit53 only, in_exp=1023, grs=000 → 3 cycles later out_exp=1024, frac=0, flags=0.
- Left normalise: in_mant=1<<40, in_exp=1023 → out_exp=1011, frac=0. With in_exp=5 → subnormal, out_exp=0, frac=1<<44.
- RNE ties: mant=bit52|1, grs=100 → frac=2, inexact. mant=bit52, grs=100 → frac=0, inexact.
- Overflow: in_exp=2046, in_mant=bit53 → out_exp=2047, frac=0, flags=overflow|inexact.
- Backpressure: 5 back-to-back beats, out_ready low 6 cycles → in_ready drops after 3 accepted. All 5 results emerge in order after release.
